// File: rtl/dtlb_assoc_stage_if.sv
// dtlb_assoc_stage_if: request, install/flush and registered-result bundle of the translate slot
interface dtlb_assoc_stage_if #(
  parameter int N_THREADS = 4,
  parameter int VADDR_W = 32,
  parameter int PADDR_W = 20,
  parameter int PAGE_W = 12
);
  localparam int TID_W = N_THREADS > 1 ? $clog2(N_THREADS) : 1;
  localparam int VPN_W = VADDR_W - PAGE_W;
  localparam int PPN_W = PADDR_W - PAGE_W;
  logic req_valid;
  logic [TID_W-1:0] req_thread;
  logic req_mode;
  logic req_mem;
  logic [VADDR_W-1:0] req_vaddr;
  logic hold;
  logic write_en;
  logic [TID_W-1:0] write_thread;
  logic [VPN_W-1:0] write_vpn;
  logic [PPN_W-1:0] write_ppn;
  logic flush_en;
  logic flush_all;
  logic [TID_W-1:0] flush_thread;
  logic out_valid;
  logic [TID_W-1:0] out_thread;
  logic out_miss;
  logic [PADDR_W-1:0] out_paddr;
  logic [15:0] perf_misses;
  modport master (
    output req_valid, req_thread, req_mode, req_mem, req_vaddr, hold,
    output write_en, write_thread, write_vpn, write_ppn,
    output flush_en, flush_all, flush_thread,
    input out_valid, out_thread, out_miss, out_paddr, perf_misses
  );
  modport slave (
    input req_valid, req_thread, req_mode, req_mem, req_vaddr, hold,
    input write_en, write_thread, write_vpn, write_ppn,
    input flush_en, flush_all, flush_thread,
    output out_valid, out_thread, out_miss, out_paddr, perf_misses
  );
endinterface

// File: rtl/dtlb_assoc_stage.sv
// dtlb_assoc_stage: fully-associative thread-tagged data TLB with registered translate result
module dtlb_assoc_stage #(
  parameter int N_ENTRIES = 8,
  parameter int VADDR_W = 32,
  parameter int PADDR_W = 20,
  parameter int PAGE_W = 12,
  parameter int N_THREADS = 4
) (
  input logic clk,
  input logic rst,
  dtlb_assoc_stage_if.slave bus
);
  localparam int VPN_W = VADDR_W - PAGE_W;
  localparam int PPN_W = PADDR_W - PAGE_W;
  localparam int TID_W = N_THREADS > 1 ? $clog2(N_THREADS) : 1;
  localparam int IDX_W = $clog2(N_ENTRIES);
  logic [N_ENTRIES-1:0] v, vf;
  logic [TID_W-1:0] tid [N_ENTRIES];
  logic [VPN_W-1:0] vpn [N_ENTRIES];
  logic [PPN_W-1:0] ppn [N_ENTRIES];
  logic [IDX_W-1:0] ptr, midx, fidx, widx;
  logic hit, mfound, ffound, n_miss;
  logic [PPN_W-1:0] hit_ppn;
  logic [PADDR_W-1:0] n_paddr;
  // lookup on pre-update contents; install choice on post-flush validity; descending scan so lowest index wins
  always_comb begin
    vf = v;
    hit = 1'b0;
    hit_ppn = '0;
    mfound = 1'b0;
    ffound = 1'b0;
    midx = '0;
    fidx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      vf[i] = v[i] && !(bus.flush_en && (bus.flush_all || tid[i] == bus.flush_thread));
      if (v[i] && tid[i] == bus.req_thread && vpn[i] == bus.req_vaddr[VADDR_W-1:PAGE_W]) begin
        hit = 1'b1;
        hit_ppn = ppn[i];
      end
      if (vf[i] && tid[i] == bus.write_thread && vpn[i] == bus.write_vpn) begin
        mfound = 1'b1;
        midx = IDX_W'(i);
      end
      if (!vf[i]) begin
        ffound = 1'b1;
        fidx = IDX_W'(i);
      end
    end
  end
  assign widx = mfound ? midx : ffound ? fidx : ptr;
  assign n_miss = !bus.req_mode && !hit && bus.req_valid && bus.req_mem;
  assign n_paddr = bus.req_mode ? bus.req_vaddr[PADDR_W-1:0] : hit ? {hit_ppn, bus.req_vaddr[PAGE_W-1:0]} : '0;
  // validity, replacement pointer, output stage and miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      ptr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_thread <= '0;
      bus.out_miss <= 1'b0;
      bus.out_paddr <= '0;
      bus.perf_misses <= '0;
    end else begin
      v <= vf;
      if (bus.write_en) v[widx] <= 1'b1;
      if (bus.write_en && !mfound && !ffound) ptr <= ptr + 1'b1;
      if (!bus.hold) begin
        bus.out_valid <= bus.req_valid;
        bus.out_thread <= bus.req_thread;
        bus.out_miss <= n_miss;
        bus.out_paddr <= n_paddr;
        if (n_miss && bus.perf_misses != 16'hFFFF) bus.perf_misses <= bus.perf_misses + 16'd1;
      end
    end
  end
  // entry payload; validity alone decides whether a slot is live, so no reset needed
  always_ff @(posedge clk) begin
    if (bus.write_en) begin
      tid[widx] <= bus.write_thread;
      vpn[widx] <= bus.write_vpn;
      ppn[widx] <= bus.write_ppn;
    end
  end
endmodule

// File: doc/dtlb_assoc_stage.md
Name: dtlb_assoc_stage

Overview:
- Parametrised, fully-associative, thread-tagged data TLB with a registered output stage. It is the translate slot of the TL stage.
- Translates EX-stage virtual addresses to physical addresses in one cycle and reports misses to the dcache/WB path.
- Supervisor mode bypasses translation.
- Adds what the previous generation lacked: configurable depth and widths, per-thread tags, no-duplicate install, round-robin replacement, per-thread and global flush, output hold on stall, and a saturating miss counter.

Parameters:
- N_ENTRIES, 8, number of TLB entries; power of two, >= 2.
- VADDR_W, 32, virtual address width.
- PADDR_W, 20, physical address width.
- PAGE_W, 12, page offset width. VPN_W = VADDR_W-PAGE_W; PPN_W = PADDR_W-PAGE_W.
- N_THREADS, 4, number of hardware threads. TID_W = clog2(N_THREADS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EX instruction valid
- req_thread  in  TID_W  requesting thread
- req_mode  in  1  1 = supervisor (bypass), 0 = user
- req_mem  in  1  instruction is a load/store
- req_vaddr  in  VADDR_W  virtual address
- hold  in  1  stall: output registers keep their value
- write_en  in  1  install translation
- write_thread  in  TID_W  owner thread of installed entry
- write_vpn  in  VPN_W  virtual page number
- write_ppn  in  PPN_W  physical page number
- flush_en  in  1  invalidate entries
- flush_all  in  1  with flush_en: 1 = all entries, 0 = only flush_thread
- flush_thread  in  TID_W  thread to flush
- out_valid  out  1  registered req_valid
- out_thread  out  TID_W  registered req_thread
- out_miss  out  1  registered DTLB miss
- out_paddr  out  PADDR_W  registered physical address
- perf_misses  out  16  saturating miss count

Behaviour:
- Reset (takes priority over everything, including hold):
  - all entries invalid, replacement pointer 0;
  - out_valid, out_thread, out_miss, out_paddr and perf_misses all 0.
- Entry fields: valid, tid, vpn, ppn. Entry i hits when valid && tid==req_thread && vpn==req_vaddr[VADDR_W-1:PAGE_W].
- Lookup is combinational on current inputs against pre-update array contents. There is no write-to-lookup bypass; a write is visible to a lookup in the following cycle.
- At most one entry can hit, guaranteed by the install rule. Lowest index wins defensively.
- Next-state output values:
  - supervisor (req_mode=1): miss=0, paddr=req_vaddr[PADDR_W-1:0].
  - user hit: miss=0, paddr={ppn, req_vaddr[PAGE_W-1:0]}.
  - user miss: paddr=0; miss = req_valid && req_mem.
  - invalid or non-mem requests never raise miss.
- Output register, latency 1 cycle: when hold=0, capture next-state outputs plus req_valid and req_thread. When hold=1, all out_* keep their values.
- Array updates (write/flush) apply regardless of hold.
- perf_misses increments by 1 on every cycle where hold=0 and the captured miss=1. It saturates at 0xFFFF.
- Install on write_en, in priority order:
  - (a) a valid entry matching (write_thread, write_vpn) exists: overwrite its ppn; pointer unchanged.
  - (b) otherwise, the lowest-index invalid entry; pointer unchanged.
  - (c) otherwise, the entry at the pointer; pointer advances by 1 and wraps from N_ENTRIES-1 to 0.
- Flush on flush_en:
  - flush_all=1 clears valid in every entry.
  - flush_all=0 clears valid only where tid==flush_thread.
  - The pointer is not changed.
- Flush and write in the same cycle: the flush is evaluated first. The install decision uses post-flush validity, and the installed entry ends valid.
- Write with write_thread >= N_THREADS, when N_THREADS is not a power of two: entry is stored as given and never matches a legal thread. This is not checked.

Test Plan:
- Reset, then user mem lookup thread1 vaddr 0x00003ABC -> next cycle out_valid=1, out_miss=1, out_paddr=0x00000, perf_misses=1.
- Write thread1 vpn 0x00003 ppn 0x5A, then lookup 0x00003ABC:
  - thread1 -> out_paddr=0x5AABC, out_miss=0;
  - thread2 -> out_miss=1.
- Supervisor mode, vaddr 0x12345678, empty TLB -> out_paddr=0x45678, out_miss=0.
- Replacement and re-install:
  - fill thread0 vpn 0..7, then write vpn 8 -> replaces entry 0 (pointer becomes 1);
  - lookup vpn 0 misses, vpn 1 hits;
  - rewrite vpn 3 ppn 0x77 -> same entry updated, pointer stays 1, lookup vpn3 gives ppn 0x77.
- Flushes:
  - entries for threads 0 and 1, flush_en with flush_all=0, flush_thread=0 -> thread0 lookups miss, thread1 lookups hit;
  - flush_all plus write vpn 0x10 in the same cycle -> only vpn 0x10 hits afterwards.
- Hold and same-cycle write:
  - hold=1 while a new missing request is presented -> out_* unchanged, perf_misses unchanged;
  - write and lookup of the same vpn in one cycle -> that lookup misses, the identical lookup next cycle hits;
  - rst asserted while hold=1 -> outputs 0.
